// File: rtl/interp_frame_sequencer.sv
// Frame sequencer between the RIFFA RX/TX channels and the bicubic control_unit.
// Optional build macro SEQ_SATURATE_EN clamps output pixels to 0..255 instead of truncating.
module interp_frame_sequencer #(
   parameter int OUT_ROWS   = 128,
   parameter int OUT_COLS   = 128,
   parameter int MAX_DIM    = 512,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        abort,
   input  logic        rx_valid,
   input  logic [63:0] rx_data,
   output logic        rx_ready,
   output logic [31:0] cu_rows,
   output logic [31:0] cu_cols,
   output logic        cu_run,
   output logic [63:0] cu_data,
   output logic        cu_valid,
   input  logic [31:0] cu_pixel,
   input  logic        cu_pixel_valid,
   output logic        tx_valid,
   output logic [63:0] tx_data,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int TOTAL  = OUT_ROWS * OUT_COLS;
   localparam int OCW    = $clog2(TOTAL) + 1;
   localparam int DW     = $clog2(MAX_DIM + 1);
   localparam int AREA_W = 2 * DW;
   localparam int ICW    = AREA_W - 2;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;

   localparam logic [OCW-1:0] TOTAL_C   = OCW'(TOTAL);
   localparam logic [CW-1:0]  STALL_LVL = CW'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0]  FULL_LVL  = CW'(FIFO_DEPTH);
   localparam logic [31:0]    MAX_C     = 32'(MAX_DIM);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ICW-1:0]    in_cnt;
   logic [OCW-1:0]    out_cnt;
   logic [2:0]        pk_idx;
   logic [55:0]       packer;
   logic [63:0]       pk_word;
   logic [7:0]        pix_byte;
   logic [63:0]       fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     fifo_count;

   logic [31:0]       hdr_rows, hdr_cols;
   logic [AREA_W-1:0] hdr_area;
   logic              hdr_ok, stall, rx_xfer, hdr_take, load_xfer;
   logic              pix_take, push, pop, full, push_ok, overflow;

   // Output pixel reduction to one byte
   function automatic logic [7:0] to_byte(input logic signed [31:0] p);
`ifdef SEQ_SATURATE_EN
      if (p < 0)
         return 8'h00;
      else if (p > 32'sd255)
         return 8'hFF;
      else
         return p[7:0];
`else
      return p[7:0];
`endif
   endfunction

   assign hdr_rows = rx_data[31:0];
   assign hdr_cols = rx_data[63:32];
   assign hdr_area = AREA_W'(hdr_rows[DW-1:0]) * AREA_W'(hdr_cols[DW-1:0]);
   assign hdr_ok   = (hdr_rows != 32'd0) && (hdr_rows <= MAX_C) &&
                     (hdr_cols != 32'd0) && (hdr_cols <= MAX_C) &&
                     (hdr_area[2:0] == 3'd0);

   assign stall     = fifo_count >= STALL_LVL;
   assign rx_xfer   = rx_valid && rx_ready;
   assign hdr_take  = (state == IDLE) && rx_xfer;
   assign load_xfer = (state == LOAD) && rx_xfer;

   assign tx_valid = fifo_count != '0;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 64'd0;

   assign pix_take = cu_pixel_valid && ((state == LOAD) || (state == DRAIN)) && (out_cnt != TOTAL_C);
   assign pix_byte = to_byte(cu_pixel);
   assign pk_word  = {pix_byte, packer};
   assign push     = pix_take && (pk_idx == 3'd7);
   assign pop      = tx_valid && tx_ready;
   assign full     = fifo_count == FULL_LVL;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push_ok  = push && (!full || pop);
   assign overflow = push && full && !pop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      cu_run    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            rx_ready = !abort;
            if (rx_valid && !abort && hdr_ok)
               state_nxt = LOAD;
         end
         LOAD: begin
            cu_run   = 1'b1;
            rx_ready = !abort && !stall;
            if (rx_valid && rx_ready && (in_cnt == ICW'(1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            cu_run = 1'b1;
            if ((out_cnt == TOTAL_C) && (fifo_count == '0))
               state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort)
         state_nxt = IDLE;
      if (reset)
         rx_ready = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cu_rows    <= '0;
         cu_cols    <= '0;
         cu_data    <= '0;
         cu_valid   <= 1'b0;
         err        <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         pk_idx     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (abort) begin
         cu_rows    <= '0;
         cu_cols    <= '0;
         cu_data    <= '0;
         cu_valid   <= 1'b0;
         err        <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         pk_idx     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         err      <= 1'b0;
         cu_valid <= 1'b0;
         if (hdr_take) begin
            if (hdr_ok) begin
               cu_rows <= hdr_rows;
               cu_cols <= hdr_cols;
               in_cnt  <= ICW'(hdr_area >> 3);
               out_cnt <= '0;
               pk_idx  <= '0;
            end else begin
               err <= 1'b1;
            end
         end
         if (load_xfer) begin
            cu_data  <= rx_data;
            cu_valid <= 1'b1;
            in_cnt   <= in_cnt - ICW'(1);
         end
         if (pix_take) begin
            pk_idx  <= pk_idx + 3'd1;
            out_cnt <= out_cnt + OCW'(1);
         end
         if (overflow)
            err <= 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
      end
   end

   // Packed-word storage: occupancy is tracked above, so contents need no reset
   always_ff @(posedge clock) begin
      if (pix_take)
         packer <= pk_word[63:8];
      if (push_ok)
         fifo_mem[wr_ptr] <= pk_word;
   end

endmodule
